// File: rtl/rgb_frame_aligner.sv
// Frame aligner: repairs a tuser/tlast-marked RGB stream into exact HEIGHT x WIDTH frames.
// Optional saturating error counters are enabled with FRAME_ALIGNER_STATS_EN.
module rgb_frame_aligner #(
    parameter int          HEIGHT    = 600,
    parameter int          WIDTH     = 800,
    parameter logic [7:0]  PAD_VALUE = 8'h00
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        slave_tvalid_i,
    output logic        slave_tready_o,
    input  logic [7:0]  slave_red_i,
    input  logic [7:0]  slave_green_i,
    input  logic [7:0]  slave_blue_i,
    input  logic        slave_tuser_i,
    input  logic        slave_tlast_i,
    output logic        master_tvalid_o,
    input  logic        master_tready_i,
    output logic [7:0]  master_red_o,
    output logic [7:0]  master_green_o,
    output logic [7:0]  master_blue_o,
    output logic        master_tlast_o,
`ifdef FRAME_ALIGNER_STATS_EN
    output logic [15:0] short_line_count_o,
    output logic [15:0] long_line_count_o,
    output logic [15:0] short_frame_count_o,
`endif
    output logic [2:0]  debug_state_o
);
    // Handshake: a beat transfers on a rising edge where tvalid & tready are both high;
    // master data is held stable while master_tvalid_o & !master_tready_i.
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        WAIT_SOF  = 3'd0,
        PASS      = 3'd1,
        PAD_LINE  = 3'd2,
        DROP_LINE = 3'd3,
        PAD_FRAME = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          slot_free, load, load_pad;
    logic          row_last, col_last, last_pix, at_origin;

    assign slot_free     = !master_tvalid_o || master_tready_i;
    assign row_last      = (row == ROW_LAST);
    assign col_last      = (col == COL_LAST);
    assign last_pix      = row_last && col_last;
    assign at_origin     = (row == '0) && (col == '0);
    assign debug_state_o = state;

    always_comb begin
        state_n        = state;
        slave_tready_o = 1'b0;
        load           = 1'b0;
        load_pad       = 1'b0;
        case (state)
            WAIT_SOF: begin
                slave_tready_o = slave_tuser_i ? slot_free : 1'b1;
                if (slave_tvalid_i && slave_tuser_i && slot_free) begin
                    load    = 1'b1;
                    state_n = slave_tlast_i ? PAD_LINE : PASS;
                end
            end
            PASS: begin
                // A new SOF mid-frame is held at the input until the frame is padded out.
                if (slave_tuser_i && !at_origin) begin
                    if (slave_tvalid_i) state_n = PAD_FRAME;
                end else begin
                    slave_tready_o = slot_free;
                    if (slave_tvalid_i && slot_free) begin
                        load = 1'b1;
                        if (slave_tlast_i && !col_last)      state_n = PAD_LINE;
                        else if (last_pix)                   state_n = WAIT_SOF;
                        else if (!slave_tlast_i && col_last) state_n = DROP_LINE;
                    end
                end
            end
            PAD_LINE: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_pad = 1'b1;
                    if (col_last) state_n = row_last ? WAIT_SOF : PASS;
                end
            end
            DROP_LINE: begin
                slave_tready_o = !slave_tuser_i;
                if (slave_tvalid_i) begin
                    if (slave_tuser_i)      state_n = PAD_FRAME;
                    else if (slave_tlast_i) state_n = PASS;
                end
            end
            PAD_FRAME: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_pad = 1'b1;
                    if (last_pix) state_n = WAIT_SOF;
                end
            end
            default: state_n = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            master_tvalid_o <= 1'b0;
            master_tlast_o  <= 1'b0;
            master_red_o    <= '0;
            master_green_o  <= '0;
            master_blue_o   <= '0;
        end else if (load) begin
            master_tvalid_o <= 1'b1;
            master_tlast_o  <= last_pix;
            master_red_o    <= load_pad ? PAD_VALUE : slave_red_i;
            master_green_o  <= load_pad ? PAD_VALUE : slave_green_i;
            master_blue_o   <= load_pad ? PAD_VALUE : slave_blue_i;
        end else if (master_tready_i) begin
            master_tvalid_o <= 1'b0;
        end
    end

`ifdef FRAME_ALIGNER_STATS_EN
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            short_line_count_o  <= '0;
            long_line_count_o   <= '0;
            short_frame_count_o <= '0;
        end else begin
            if (state == PASS && state_n == PAD_LINE && short_line_count_o != 16'hFFFF)
                short_line_count_o <= short_line_count_o + 1'b1;
            if (state != DROP_LINE && state_n == DROP_LINE && long_line_count_o != 16'hFFFF)
                long_line_count_o <= long_line_count_o + 1'b1;
            if (state != PAD_FRAME && state_n == PAD_FRAME && short_frame_count_o != 16'hFFFF)
                short_frame_count_o <= short_frame_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb_frame_aligner.sv
// Directed bench for rgb_frame_aligner (HEIGHT=2, WIDTH=4) with an expected-pixel queue.
module tb_rgb_frame_aligner;
    localparam logic [7:0] PAD = 8'h00;

    logic        clock_i = 1'b0;
    logic        reset_ni;
    logic        slave_tvalid_i, slave_tready_o, slave_tuser_i, slave_tlast_i;
    logic [7:0]  slave_red_i, slave_green_i, slave_blue_i;
    logic        master_tvalid_o, master_tready_i, master_tlast_o;
    logic [7:0]  master_red_o, master_green_o, master_blue_o;
    logic [2:0]  debug_state_o;
`ifdef FRAME_ALIGNER_STATS_EN
    logic [15:0] short_line_count_o, long_line_count_o, short_frame_count_o;
`endif

    logic [24:0] exp_q[$];
    int          total = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          w;
    logic        stalled = 1'b0;
    logic [24:0] held;

    rgb_frame_aligner #(.HEIGHT(2), .WIDTH(4), .PAD_VALUE(PAD)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .slave_tvalid_i(slave_tvalid_i), .slave_tready_o(slave_tready_o),
        .slave_red_i(slave_red_i), .slave_green_i(slave_green_i), .slave_blue_i(slave_blue_i),
        .slave_tuser_i(slave_tuser_i), .slave_tlast_i(slave_tlast_i),
        .master_tvalid_o(master_tvalid_o), .master_tready_i(master_tready_i),
        .master_red_o(master_red_o), .master_green_o(master_green_o), .master_blue_o(master_blue_o),
        .master_tlast_o(master_tlast_o),
`ifdef FRAME_ALIGNER_STATS_EN
        .short_line_count_o(short_line_count_o), .long_line_count_o(long_line_count_o),
        .short_frame_count_o(short_frame_count_o),
`endif
        .debug_state_o(debug_state_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops on each transfer, and checks held data across stalls.
    always @(negedge clock_i) begin
        if (!reset_ni) begin
            stalled = 1'b0;
        end else begin
            if (stalled && master_tvalid_o)
                check("stall_hold", {7'd0, master_tlast_o, master_red_o, master_green_o, master_blue_o},
                      {7'd0, held});
            if (master_tvalid_o && master_tready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    fail_cnt++;
                    $error("FAIL spurious_out got=%0h exp=none",
                           {master_tlast_o, master_red_o, master_green_o, master_blue_o});
                end else begin
                    check("out_pixel", {7'd0, master_tlast_o, master_red_o, master_green_o, master_blue_o},
                          {7'd0, exp_q.pop_front()});
                end
            end
            stalled = master_tvalid_o && !master_tready_i;
            held    = {master_tlast_o, master_red_o, master_green_o, master_blue_o};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [7:0] r, g, b, input logic u, l, output int waited);
        logic acc;
        slave_tvalid_i = 1'b1;
        slave_red_i = r; slave_green_i = g; slave_blue_i = b;
        slave_tuser_i = u; slave_tlast_i = l;
        waited = 0;
        forever begin
            @(negedge clock_i);
            acc = slave_tready_o;
            @(posedge clock_i);
            #1;
            if (acc) break;
            waited++;
            if (waited >= 64) begin
                total++;
                fail_cnt++;
                $error("FAIL send_timeout got=stalled exp=accept");
                break;
            end
        end
    endtask

    task automatic send_exp(input logic u, l, el, output int waited);
        logic [7:0] r, g, b;
        r = 8'($urandom_range(1, 255));
        g = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        exp_q.push_back({el, r, g, b});
        send(r, g, b, u, l, waited);
    endtask

    task automatic send_drop(input logic u, l, output int waited);
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), u, l, waited);
    endtask

    task automatic push_pad(input logic el);
        exp_q.push_back({el, PAD, PAD, PAD});
    endtask

    task automatic idle(input int n);
        slave_tvalid_i = 1'b0;
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    initial begin
        reset_ni = 1'b0;
        slave_tvalid_i = 1'b0; slave_tuser_i = 1'b0; slave_tlast_i = 1'b0;
        slave_red_i = '0; slave_green_i = '0; slave_blue_i = '0;
        master_tready_i = 1'b1;
        #12;
        check("rst_tvalid", master_tvalid_o, 0);
        check("rst_tlast", master_tlast_o, 0);
        check("rst_rgb", {master_red_o, master_green_o, master_blue_o}, 0);
        check("rst_tready", slave_tready_o, 1);
        check("rst_state", debug_state_o, 0);
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(posedge clock_i);
        #1;

        // Clean frame
        for (int i = 0; i < 8; i++) begin
            send_exp(i == 0, i == 3 || i == 7, i == 7, w);
            check("clean_wait", w, 0);
        end
        idle(2);

        // Short line: two pixels then two pads, row 1 stalls for the pads
        send_exp(1, 0, 0, w);
        send_exp(0, 1, 0, w);
        push_pad(0);
        push_pad(0);
        for (int i = 0; i < 4; i++) begin
            send_exp(0, i == 3, i == 3, w);
            if (i == 0) check("short_pad_stall", w, 2);
        end
        idle(2);
`ifdef FRAME_ALIGNER_STATS_EN
        check("short_line_count", short_line_count_o, 1);
`endif

        // Long line: six pixels on row 0, last two dropped
        for (int i = 0; i < 4; i++) send_exp(i == 0, 0, 0, w);
        send_drop(0, 0, w);
        check("long_drop_wait", w, 0);
        send_drop(0, 1, w);
        check("long_drop_wait", w, 0);
        for (int i = 0; i < 4; i++) send_exp(0, i == 3, i == 3, w);
        idle(2);
`ifdef FRAME_ALIGNER_STATS_EN
        check("long_line_count", long_line_count_o, 1);
`endif

        // Early SOF at (1,1): three pads, then new frame from (0,0)
        for (int i = 0; i < 5; i++) send_exp(i == 0, i == 3, 0, w);
        push_pad(0);
        push_pad(0);
        push_pad(1);
        send_exp(1, 0, 0, w);
        check("early_sof_stall", w, 4);
        for (int i = 1; i < 8; i++) send_exp(0, i == 3 || i == 7, i == 7, w);
        idle(2);
`ifdef FRAME_ALIGNER_STATS_EN
        check("short_frame_count", short_frame_count_o, 1);
`endif

        // Junk before SOF, then a frame with master_tready_i 1,0,0,1
        for (int i = 0; i < 5; i++) begin
            send_drop(0, i == 2, w);
            check("junk_wait", w, 0);
        end
        send_exp(1, 0, 0, w);
        send_exp(0, 0, 0, w);
        master_tready_i = 1'b0;
        fork
            send_exp(0, 0, 0, w);
            begin
                repeat (2) @(posedge clock_i);
                #1;
                master_tready_i = 1'b1;
            end
        join
        for (int i = 3; i < 8; i++) send_exp(0, i == 3 || i == 7, i == 7, w);
        idle(2);
`ifdef FRAME_ALIGNER_STATS_EN
        check("short_line_count_end", short_line_count_o, 1);
        check("long_line_count_end", long_line_count_o, 1);
`endif

        // Asynchronous reset mid-row; pixel 1 is discarded in the output register
        send_exp(1, 0, 0, w);
        send_drop(0, 0, w);
        slave_tvalid_i = 1'b0;
        check("pre_rst_tvalid", master_tvalid_o, 1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_rst_tvalid", master_tvalid_o, 0);
        check("async_rst_tready", slave_tready_o, 1);
        check("async_rst_q", exp_q.size(), 0);
        @(negedge clock_i);
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(posedge clock_i);
        #1;
        for (int i = 0; i < 8; i++) send_exp(i == 0, i == 3 || i == 7, i == 7, w);
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock_i);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("end_state", debug_state_o, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
